// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph table (active-low, bit0=a .. bit6=g) and decoded digit codes.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_BAD   = 4'hE;

  typedef struct packed {
    logic       err;
    logic [3:0] code;
  } glyph_t;

endpackage

// File: rtl/seg7_pattern_encoder.sv
// Combinational reverse lookup: active-low segment pattern -> BCD code plus illegal-glyph flag.
module seg7_pattern_encoder
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n_i,
  output glyph_t     glyph_o
);

  always_comb begin
    glyph_o = '{err: 1'b1, code: DIG_BAD};
    case (seg_n_i)
      SEG_0:     glyph_o = '{err: 1'b0, code: 4'd0};
      SEG_1:     glyph_o = '{err: 1'b0, code: 4'd1};
      SEG_2:     glyph_o = '{err: 1'b0, code: 4'd2};
      SEG_3:     glyph_o = '{err: 1'b0, code: 4'd3};
      SEG_4:     glyph_o = '{err: 1'b0, code: 4'd4};
      SEG_5:     glyph_o = '{err: 1'b0, code: 4'd5};
      SEG_6:     glyph_o = '{err: 1'b0, code: 4'd6};
      SEG_7:     glyph_o = '{err: 1'b0, code: 4'd7};
      SEG_8:     glyph_o = '{err: 1'b0, code: 4'd8};
      SEG_9:     glyph_o = '{err: 1'b0, code: 4'd9};
      SEG_BLANK: glyph_o = '{err: 1'b0, code: DIG_BLANK};
      default:   glyph_o = '{err: 1'b1, code: DIG_BAD};
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a multiplexed active-low 7-seg bus; debounces each strobe
// period and emits one parallel word per fully covered scan frame.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    scan_err
);

  localparam int unsigned      IN_W       = NUM_DIGITS + 7;
  localparam logic [CNT_W-1:0] ACCEPT_CNT = CNT_W'(STABLE_CYCLES - 1);

  logic [IN_W-1:0]                stage1_q, stage2_q;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           armed_q, armed_d;
  logic                           accept;
  logic [NUM_DIGITS-1:0]          sel, seen_q, seen_d;
  logic                           one_hot, multi, frame_done;
  logic [NUM_DIGITS-1:0][3:0]     slot_code_q, slot_code_d, digits_q;
  logic [NUM_DIGITS-1:0]          slot_err_q, slot_err_d, digit_err_q;
  logic                           frame_valid_q, scan_err_q;
  glyph_t                         glyph;

  seg7_pattern_encoder u_enc (
    .seg_n_i (stage1_q[6:0]),
    .glyph_o (glyph)
  );

  // Accept is judged on the counter's next value so the capture lands on the same edge
  // the counter reaches STABLE_CYCLES-1 (value sampled at edge E is taken at E+STABLE_CYCLES).
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (stage1_q != stage2_q) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    accept = armed_d && (cnt_d == ACCEPT_CNT);
    if (accept) armed_d = 1'b0;
  end

  always_comb begin
    sel        = ~stage1_q[IN_W-1:7];
    one_hot    = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
    multi      = (sel != '0) && !one_hot;
    frame_done = &seen_q;
  end

  always_comb begin
    seen_d      = frame_done ? '0 : seen_q;
    slot_code_d = slot_code_q;
    slot_err_d  = slot_err_q;
    if (accept && one_hot) begin
      seen_d = seen_d | sel;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (sel[i]) begin
          slot_code_d[i] = glyph.code;
          slot_err_d[i]  = glyph.err;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_q      <= {{NUM_DIGITS{1'b1}}, SEG_BLANK};
      stage2_q      <= {{NUM_DIGITS{1'b1}}, SEG_BLANK};
      cnt_q         <= '0;
      armed_q       <= 1'b0;
      seen_q        <= '0;
      slot_code_q   <= {NUM_DIGITS{DIG_BLANK}};
      slot_err_q    <= '0;
      digits_q      <= {NUM_DIGITS{DIG_BLANK}};
      digit_err_q   <= '0;
      frame_valid_q <= 1'b0;
      scan_err_q    <= 1'b0;
    end else begin
      stage1_q      <= {an_n, seg_n};
      stage2_q      <= stage1_q;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      seen_q        <= seen_d;
      slot_code_q   <= slot_code_d;
      slot_err_q    <= slot_err_d;
      frame_valid_q <= frame_done;
      scan_err_q    <= accept && multi;
      if (frame_done) begin
        digits_q    <= slot_code_q;
        digit_err_q <= slot_err_q;
      end
    end
  end

  assign digits_out  = digits_q;
  assign digit_err   = digit_err_q;
  assign frame_valid = frame_valid_q;
  assign scan_err    = scan_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench: stimulus pushes expected frames, a negedge monitor pops on frame_valid.
module tb_seg7_scan_decoder;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0011000;
  localparam logic [6:0] PB = 7'b1111111;
  localparam logic [6:0] PX = 7'b0101010;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  e;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] digits_out;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        scan_err;

  int n_chk = 0;
  int n_fail = 0;
  int frames = 0;
  int scan_pulses = 0;
  logic prev_fv = 1'b0;
  frame_t exp_q[$];

  seg7_scan_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4),
    .CNT_W         (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .digits_out  (digits_out),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .scan_err    (scan_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_n  = an;
    seg_n = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    show(4'b1111, PB, n);
  endtask

  task automatic expect_frame(input logic [15:0] d, input logic [3:0] e);
    frame_t f;
    f.d = d;
    f.e = e;
    exp_q.push_back(f);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) begin
        frames++;
        check("fv_one_cycle", 32'(prev_fv), 32'd0);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_frame: got digits=%h err=%b, required no frame", digits_out, digit_err);
        end else begin
          frame_t f;
          f = exp_q.pop_front();
          check("frame_digits", 32'(digits_out), 32'(f.d));
          check("frame_err", 32'(digit_err), 32'(f.e));
        end
      end
      if (scan_err) scan_pulses++;
      prev_fv <= frame_valid;
    end else begin
      prev_fv <= 1'b0;
    end
  end

  initial begin
    rst = 1'b1;
    an_n = 4'($urandom);
    seg_n = 7'($urandom);
    repeat (3) begin
      @(posedge clk);
      #1;
      an_n = 4'($urandom);
      seg_n = 7'($urandom);
    end
    rst = 1'b0;
    an_n = 4'b1111;
    seg_n = PB;
    check("reset_digits", 32'(digits_out), 32'hFFFF);
    check("reset_err", 32'(digit_err), 32'h0);
    check("reset_fv", 32'(frame_valid), 32'h0);
    check("reset_scan_err", 32'(scan_err), 32'h0);
    idle(4);

    // clean scan
    expect_frame(16'h1432, 4'b0000);
    show(4'b1110, P2, 8);
    show(4'b1101, P3, 8);
    show(4'b1011, P4, 8);
    show(4'b0111, P1, 8);
    idle(4);
    check("frames_clean", 32'(frames), 32'd1);

    // glitch inside a held digit, and a too-short strobe
    show(4'b1110, P5, 8);
    show(4'b1110, P8, 2);
    show(4'b1110, P5, 8);
    show(4'b1101, P9, 3);
    show(4'b1011, P6, 8);
    show(4'b0111, P7, 8);
    idle(6);
    check("partial_no_frame", 32'(frames), 32'd1);
    expect_frame(16'h7605, 4'b0000);
    show(4'b1101, P0, 8);
    idle(4);
    check("frames_glitch", 32'(frames), 32'd2);

    // illegal glyph and blank
    expect_frame(16'h8E3F, 4'b0100);
    show(4'b1110, PB, 8);
    show(4'b1101, P3, 8);
    show(4'b1011, PX, 8);
    show(4'b0111, P8, 8);
    idle(4);
    check("frames_illegal", 32'(frames), 32'd3);

    // strobe faults, then repeat of digit 1 with digit 0 last
    show(4'b1100, P1, 8);
    show(4'b1111, P8, 8);
    check("scan_err_once", 32'(scan_pulses), 32'd1);
    check("frames_fault", 32'(frames), 32'd3);
    expect_frame(16'h4972, 4'b0000);
    show(4'b1101, P5, 8);
    show(4'b1101, P7, 8);
    show(4'b1011, P9, 8);
    show(4'b0111, P4, 8);
    show(4'b1110, P2, 8);
    idle(4);
    check("frames_repeat", 32'(frames), 32'd4);

    // reset mid-frame
    show(4'b1110, P1, 8);
    show(4'b1101, P1, 8);
    show(4'b1011, P1, 8);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_digits", 32'(digits_out), 32'hFFFF);
    check("midrst_err", 32'(digit_err), 32'h0);
    expect_frame(16'h3869, 4'b0000);
    show(4'b1110, P9, 8);
    show(4'b1101, P6, 8);
    show(4'b1011, P8, 8);
    show(4'b0111, P3, 8);
    idle(6);
    check("frames_total", 32'(frames), 32'd5);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("scan_err_total", 32'(scan_pulses), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
